// File: rtl/logic_result_serializer_if.sv
// Handshake/bus bundle between the logic unit, the serializer and the shared result bus.
// slave is the serializer's view; master is the surrounding logic's view.
interface logic_result_serializer_if #(
  parameter int RES_W = 67,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             suff;
  logic [2:0]       opcode;
  logic [RES_W-1:0] andOp;
  logic [RES_W-1:0] orOp;
  logic [RES_W-1:0] xorOp;
  logic [RES_W-1:0] shiftedLX;
  logic [RES_W-1:0] shiftedRX;
  logic [RES_W-1:0] shiftedLY;
  logic [RES_W-1:0] shiftedRY;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             done;
  logic             err;

  modport slave (
    input  in_valid, suff, opcode,
    input  andOp, orOp, xorOp, shiftedLX, shiftedRX, shiftedLY, shiftedRY,
    input  out_ready,
    output in_ready, out_data, out_valid, out_last, done, err
  );

  modport master (
    output in_valid, suff, opcode,
    output andOp, orOp, xorOp, shiftedLX, shiftedRX, shiftedLY, shiftedRY,
    output out_ready,
    input  in_ready, out_data, out_valid, out_last, done, err
  );
endinterface

// File: rtl/logic_result_serializer.sv
// Captures one opcode-selected logic-unit result and streams it as OUT_W-bit words
// (least-significant first) over a valid/ready handshake, then pulses done.
module logic_result_serializer #(
  parameter int RES_W = 67,
  parameter int OUT_W = 32
) (
  input logic                        clk,
  input logic                        rst_b,
  logic_result_serializer_if.slave   bus
);
  localparam int NWORDS = (RES_W + OUT_W - 1) / OUT_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PAD_W  = NWORDS * OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [RES_W-1:0] sel_res;
  logic [PAD_W-1:0] res_padded;
  logic             in_ready, out_valid, out_last, done;

  // Reserved opcode registers zero so a bad select never leaks stale data.
  always_comb begin
    case (bus.opcode)
      3'd0:    sel_res = bus.andOp;
      3'd1:    sel_res = bus.orOp;
      3'd2:    sel_res = bus.xorOp;
      3'd3:    sel_res = bus.shiftedLX;
      3'd4:    sel_res = bus.shiftedRX;
      3'd5:    sel_res = bus.shiftedLY;
      3'd6:    sel_res = bus.shiftedRY;
      default: sel_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.suff) begin
          res_d   = sel_res;
          err_d   = (bus.opcode == 3'd7);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == LAST_CNT);
        if (bus.out_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign res_padded    = {{(PAD_W - RES_W){1'b0}}, res_q};
  assign bus.out_data  = (state_q == SEND) ? res_padded[OUT_W*int'(cnt_q) +: OUT_W] : '0;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.done      = done;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_logic_result_serializer.sv
// Directed bench for logic_result_serializer: table of result sets with expected words,
// plus hand-written stall, suff-gating and mid-transfer reset sequences.
module tb_logic_result_serializer;
  logic clk = 1'b0;
  logic rst_b;

  logic_result_serializer_if #(.RES_W(67), .OUT_W(32)) dif ();

  logic_result_serializer #(.RES_W(67), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic [6:0][66:0] res;
    logic [31:0]      w0, w1, w2;
    logic             err;
  } vec_t;

  vec_t tbl[7];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [66:0] val,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    vec_t v;
    v.name = name;
    v.op   = op;
    // Distinct background on every result so a wrong select is visible.
    for (int i = 0; i < 7; i++)
      v.res[i] = {3'h3, 32'hB0B0_0000 | 32'(i), 32'hC0C0_0000 | 32'(i)};
    if (op != 3'd7) v.res[op] = val;
    v.w0  = w0;
    v.w1  = w1;
    v.w2  = w2;
    v.err = (op == 3'd7);
    return v;
  endfunction

  task automatic drive_res(input logic [6:0][66:0] r);
    dif.andOp     = r[0];
    dif.orOp      = r[1];
    dif.xorOp     = r[2];
    dif.shiftedLX = r[3];
    dif.shiftedRX = r[4];
    dif.shiftedLY = r[5];
    dif.shiftedRY = r[6];
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; stalls word 1 for stall_cycles cycles.
  task automatic xfer(input vec_t v, input int stall_cycles);
    logic [31:0] exp_w[3];
    logic [6:0][66:0] junk;
    int f0;
    f0 = n_fail;
    exp_w[0] = v.w0;
    exp_w[1] = v.w1;
    exp_w[2] = v.w2;
    check({v.name, ".in_ready_idle"}, 32'(dif.in_ready), 32'd1);
    drive_res(v.res);
    dif.opcode   = v.op;
    dif.suff     = 1'b1;
    dif.in_valid = 1'b1;
    cyc();
    dif.in_valid = 1'b0;
    // Scramble inputs: the in-flight transfer must use the captured value only.
    for (int i = 0; i < 7; i++) junk[i] = ~v.res[i];
    drive_res(junk);
    dif.opcode = v.op ^ 3'd1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("%s.valid%0d", v.name, w), 32'(dif.out_valid), 32'd1);
      check($sformatf("%s.in_ready%0d", v.name, w), 32'(dif.in_ready), 32'd0);
      check($sformatf("%s.data%0d", v.name, w), dif.out_data, exp_w[w]);
      check($sformatf("%s.last%0d", v.name, w), 32'(dif.out_last), 32'(w == 2));
      check($sformatf("%s.err%0d", v.name, w), 32'(dif.err), 32'(v.err));
      check($sformatf("%s.done%0d", v.name, w), 32'(dif.done), 32'd0);
      if (w == 1 && stall_cycles > 0) begin
        dif.out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          cyc();
          check($sformatf("%s.stall_valid%0d", v.name, s), 32'(dif.out_valid), 32'd1);
          check($sformatf("%s.stall_data%0d", v.name, s), dif.out_data, exp_w[1]);
          check($sformatf("%s.stall_last%0d", v.name, s), 32'(dif.out_last), 32'd0);
        end
        dif.out_ready = 1'b1;
      end
      cyc();
    end
    check({v.name, ".fin_done"}, 32'(dif.done), 32'd1);
    check({v.name, ".fin_valid"}, 32'(dif.out_valid), 32'd0);
    check({v.name, ".fin_in_ready"}, 32'(dif.in_ready), 32'd0);
    check({v.name, ".fin_err"}, 32'(dif.err), 32'(v.err));
    cyc();
    check({v.name, ".post_done"}, 32'(dif.done), 32'd0);
    check({v.name, ".post_in_ready"}, 32'(dif.in_ready), 32'd1);
    check({v.name, ".post_err"}, 32'(dif.err), 32'(v.err));
    $display("xfer %-10s op=%0d stall=%0d words %h %h %h err=%0d: %0d miscompares",
             v.name, v.op, stall_cycles, v.w0, v.w1, v.w2, v.err, n_fail - f0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    tbl[0] = mk("xor", 3'd2, 67'h0_0000_0000_1004_0000, 32'h1004_0000, 32'h0, 32'h0);
    tbl[0].res[0] = 67'h0_0000_0000_4001_0000;
    tbl[0].res[1] = 67'h0_0000_0000_5005_0000;
    tbl[1] = mk("shlx", 3'd3, {3'h7, 32'h8000_0001, 32'h0}, 32'h0, 32'h8000_0001, 32'h7);
    tbl[2] = mk("shrx", 3'd4, {3'h0, 32'h7, 32'hFFFF_FFFF}, 32'hFFFF_FFFF, 32'h7, 32'h0);
    tbl[3] = mk("shly", 3'd5, {3'h5, 32'hDEAD_BEEF, 32'hCAFE_F00D},
                32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h5);
    tbl[4] = mk("shry", 3'd6, {3'h2, 32'h0123_4567, 32'h89AB_CDEF},
                32'h89AB_CDEF, 32'h0123_4567, 32'h2);
    tbl[5] = mk("or_all1", 3'd1, {3'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7);
    tbl[6] = mk("and", 3'd0, {3'h4, 32'h0000_0000, 32'h8765_4321},
                32'h8765_4321, 32'h0, 32'h4);

    dif.in_valid  = 1'b0;
    dif.suff      = 1'b0;
    dif.opcode    = 3'd0;
    dif.out_ready = 1'b1;
    drive_res(tbl[0].res);
    rst_b = 1'b0;
    cyc();
    cyc();
    check("rst.in_ready", 32'(dif.in_ready), 32'd1);
    check("rst.out_valid", 32'(dif.out_valid), 32'd0);
    check("rst.out_last", 32'(dif.out_last), 32'd0);
    check("rst.done", 32'(dif.done), 32'd0);
    check("rst.err", 32'(dif.err), 32'd0);
    check("rst.out_data", dif.out_data, 32'd0);
    rst_b = 1'b1;
    cyc();

    // Back-to-back transfers: each xfer spans exactly 5 cycles from capture to next capture.
    for (int i = 0; i < 7; i++) xfer(tbl[i], 0);

    // Stall during word 1.
    v = mk("and_stall", 3'd0, {3'h1, 32'hA5A5_0001, 32'h1234_5678},
           32'h1234_5678, 32'hA5A5_0001, 32'h1);
    xfer(v, 4);

    // suff gating: no capture while suff=0, then a reserved opcode.
    dif.in_valid = 1'b1;
    dif.suff     = 1'b0;
    dif.opcode   = 3'd7;
    for (int s = 0; s < 3; s++) begin
      cyc();
      check($sformatf("nosuff.valid%0d", s), 32'(dif.out_valid), 32'd0);
      check($sformatf("nosuff.in_ready%0d", s), 32'(dif.in_ready), 32'd1);
    end
    v = mk("reserved", 3'd7, 67'h0, 32'h0, 32'h0, 32'h0);
    xfer(v, 0);

    // Reset mid-transfer after word 0 is accepted.
    drive_res(v.res);
    dif.opcode   = 3'd7;
    dif.suff     = 1'b1;
    dif.in_valid = 1'b1;
    cyc();
    dif.in_valid = 1'b0;
    check("midrst.err_before", 32'(dif.err), 32'd1);
    check("midrst.valid_before", 32'(dif.out_valid), 32'd1);
    cyc();
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    check("midrst.out_valid", 32'(dif.out_valid), 32'd0);
    check("midrst.in_ready", 32'(dif.in_ready), 32'd1);
    check("midrst.err", 32'(dif.err), 32'd0);
    check("midrst.done", 32'(dif.done), 32'd0);
    for (int s = 0; s < 3; s++) begin
      cyc();
      check($sformatf("midrst.no_done%0d", s), 32'(dif.done), 32'd0);
      check($sformatf("midrst.idle_valid%0d", s), 32'(dif.out_valid), 32'd0);
    end
    $display("xfer midrst    reset after word 0: %0d miscompares so far", n_fail);
    v = tbl[5];
    v.name = "after_rst";
    xfer(v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
